// File: rtl/hiscore_xfer_ctrl.sv
// High-score transfer controller: pauses the core, then bridges ioctl byte strobes onto the core hs_* RAM port.
// Optional feature macro HS_CHECKSUM_EN adds a mod-256 checksum of in-range bytes on hs_chk (tied to 0 otherwise).
module hiscore_xfer_ctrl #(
    parameter logic [7:0] HS_INDEX   = 8'd2,
    parameter int         ADDR_W     = 10,
    parameter int         HS_SIZE    = 64,
    parameter int         SETTLE_CYC = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    output logic              hs_access,
    output logic [ADDR_W-1:0] hs_address,
    output logic [7:0]        hs_data_out,
    input  logic [7:0]        hs_data_in,
    output logic              hs_write,
    output logic [7:0]        hs_chk
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_READY, S_WR, S_RD1, S_RD2, S_RELEASE
    } state_t;

    localparam int          CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [24:0] HS_LIMIT = 25'(HS_SIZE);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              range_q, range_d;
    logic              pause_d, wait_d, access_d, write_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        dout_d, din_d;

    logic session, in_range, wr_go, rd_go;

    // Download wins when both directions are asserted; the range check sees all 25 bits.
    assign session  = (ioctl_download | ioctl_upload) && (ioctl_index == HS_INDEX);
    assign in_range = ioctl_addr < HS_LIMIT;
    assign wr_go    = session && ioctl_download && ioctl_wr;
    assign rd_go    = session && !ioctl_download && ioctl_upload && ioctl_rd;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            range_q     <= 1'b0;
            pause_req   <= 1'b0;
            ioctl_wait  <= 1'b0;
            hs_access   <= 1'b0;
            hs_write    <= 1'b0;
            hs_address  <= '0;
            hs_data_out <= 8'h00;
            ioctl_din   <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            range_q     <= range_d;
            pause_req   <= pause_d;
            ioctl_wait  <= wait_d;
            hs_access   <= access_d;
            hs_write    <= write_d;
            hs_address  <= addr_d;
            hs_data_out <= dout_d;
            ioctl_din   <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        range_d  = range_q;
        pause_d  = pause_req;
        wait_d   = ioctl_wait;
        access_d = hs_access;
        write_d  = 1'b0;
        addr_d   = hs_address;
        dout_d   = hs_data_out;
        din_d    = ioctl_din;
        case (state_q)
            S_IDLE: begin
                if (session) begin
                    state_d = S_SETTLE;
                    pause_d = 1'b1;
                    wait_d  = 1'b1;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d  = S_READY;
                    access_d = 1'b1;
                    wait_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_READY: begin
                if (!session) begin
                    state_d  = S_RELEASE;
                    access_d = 1'b0;
                    pause_d  = 1'b0;
                    wait_d   = 1'b0;
                end else if (wr_go) begin
                    state_d = S_WR;
                    wait_d  = 1'b1;
                    write_d = in_range;
                    addr_d  = ioctl_addr[ADDR_W-1:0];
                    dout_d  = ioctl_dout;
                end else if (rd_go) begin
                    state_d = S_RD1;
                    wait_d  = 1'b1;
                    addr_d  = ioctl_addr[ADDR_W-1:0];
                    range_d = in_range;
                end
            end
            S_RD1: state_d = S_RD2;
            S_WR, S_RD2: begin
                // Core data is valid during RD2 (one cycle after the address); sample it on the way out.
                if (state_q == S_RD2) din_d = range_q ? hs_data_in : 8'hFF;
                wait_d = 1'b0;
                if (session) begin
                    state_d = S_READY;
                end else begin
                    state_d  = S_RELEASE;
                    access_d = 1'b0;
                    pause_d  = 1'b0;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default: begin
                state_d  = S_IDLE;
                pause_d  = 1'b0;
                wait_d   = 1'b0;
                access_d = 1'b0;
            end
        endcase
    end

`ifdef HS_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_chk <= 8'h00;
        end else if (state_q == S_IDLE && session) begin
            hs_chk <= 8'h00;
        end else if (state_q == S_READY && wr_go && in_range) begin
            hs_chk <= hs_chk + ioctl_dout;
        end else if (state_q == S_RD2 && range_q) begin
            hs_chk <= hs_chk + hs_data_in;
        end
    end
`else
    assign hs_chk = 8'h00;
`endif

endmodule

// File: tb/tb_hiscore_xfer_ctrl.sv
// Bench for hiscore_xfer_ctrl: table vectors, randomized transfers against a byte-array model, and corner sequences.
module tb_hiscore_xfer_ctrl;
    localparam int HS_SIZE = 64;
    localparam int SETTLE  = 8;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
    logic [7:0]  ioctl_index, ioctl_dout, ioctl_din, hs_data_out, hs_data_in, hs_chk;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait, pause_req, hs_access, hs_write;
    logic [9:0]  hs_address;

    hiscore_xfer_ctrl dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_rd(ioctl_rd),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
        .hs_access(hs_access), .hs_address(hs_address), .hs_data_out(hs_data_out),
        .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_chk(hs_chk)
    );

    always #5 clk_sys = ~clk_sys;

    // Core-side RAM with one cycle of read latency.
    logic [7:0] core_ram [0:1023];
    always @(posedge clk_sys) begin
        if (hs_write) core_ram[hs_address] <= hs_data_out;
        hs_data_in <= core_ram[hs_address];
    end

    // Reference model: the image the core RAM should hold, plus the session checksum.
    logic [7:0] exp_img [0:1023];
    logic [7:0] exp_chk;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_wr;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_write;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic start_session(input logic dl, input logic ul);
        ioctl_index    = 8'd2;
        ioctl_download = dl;
        ioctl_upload   = ul;
        exp_chk        = 8'h00;
        step();
        check("settle_pause", pause_req, 1);
        check("settle_wait", ioctl_wait, 1);
        for (int k = 1; k < SETTLE; k++) begin
            step();
            if (hs_access !== 1'b0 || ioctl_wait !== 1'b1)
                check("settle_hold", {hs_access, ioctl_wait}, 2'b01);
        end
        step();
        check("ready_access", hs_access, 1);
        check("ready_wait", ioctl_wait, 0);
    endtask

    task automatic end_session();
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        step();
        step();
        check("end_pause", pause_req, 0);
        check("end_access", hs_access, 0);
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d, input logic exp_wr);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr = 1'b0;
        check("wr_pulse", hs_write, exp_wr);
        check("wr_wait", ioctl_wait, 1);
        if (exp_wr) begin
            check("wr_addr", hs_address, a[9:0]);
            check("wr_data", hs_data_out, d);
        end
        step();
        check("wr_done_pulse", hs_write, 0);
        check("wr_done_wait", ioctl_wait, 0);
    endtask

    task automatic do_read(input logic [24:0] a, input logic [7:0] exp_din);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        step();
        ioctl_rd = 1'b0;
        check("rd1_wait", ioctl_wait, 1);
        check("rd1_addr", hs_address, a[9:0]);
        step();
        check("rd2_wait", ioctl_wait, 1);
        step();
        check("rd_wait_low", ioctl_wait, 0);
        check("rd_din", ioctl_din, exp_din);
    endtask

    task automatic model_write(input logic [24:0] a, input logic [7:0] d);
        if (a < HS_SIZE) begin
            exp_img[a[9:0]] = d;
            exp_chk         = exp_chk + d;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [24:0] a);
        return (a < HS_SIZE) ? exp_img[a[9:0]] : 8'hFF;
    endfunction

    task automatic check_chk(input string name);
`ifdef HS_CHECKSUM_EN
        check(name, hs_chk, exp_chk);
`else
        check(name, hs_chk, 0);
`endif
    endtask

    initial begin
        logic [24:0] ra;
        logic [7:0]  rd_exp;
        int diffs;

        vecs[0]  = '{1'b1, 25'd5,        8'hA7, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 25'd0,        8'h11, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 25'd63,       8'hFE, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 25'd64,       8'h55, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 25'd1029,     8'h66, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 25'h1000000,  8'h77, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 25'd5,        8'h00, 1'b0, 8'hA7};
        vecs[7]  = '{1'b0, 25'd3,        8'h00, 1'b0, 8'h3C};
        vecs[8]  = '{1'b0, 25'd0,        8'h00, 1'b0, 8'h11};
        vecs[9]  = '{1'b0, 25'd63,       8'h00, 1'b0, 8'hFE};
        vecs[10] = '{1'b0, 25'd64,       8'h00, 1'b0, 8'hFF};
        vecs[11] = '{1'b0, 25'd100,      8'h00, 1'b0, 8'hFF};
        vecs[12] = '{1'b0, 25'd1029,     8'h00, 1'b0, 8'hFF};

        for (int i = 0; i < 1024; i++) begin
            core_ram[i] = 8'(i * 7 + 1);
            exp_img[i]  = 8'(i * 7 + 1);
        end
        core_ram[3] = 8'h3C;
        exp_img[3]  = 8'h3C;
        exp_chk     = 8'h00;

        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
        ioctl_addr = '0; ioctl_wr = 1'b0; ioctl_dout = 8'h00; ioctl_rd = 1'b0;
        repeat (3) step();
        check("rst_pause", pause_req, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_access", hs_access, 0);
        check("rst_write", hs_write, 0);
        check("rst_din", ioctl_din, 8'hFF);
        check("rst_chk", hs_chk, 0);
        reset = 1'b0;

        // Other indices must not start a session.
        ioctl_index = 8'd3;
        ioctl_download = 1'b1;
        repeat (3) step();
        check("wrong_index_pause", pause_req, 0);
        ioctl_download = 1'b0;
        step();

        start_session(1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_write);
                model_write(vecs[i].addr, vecs[i].data);
            end
        end
        ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        check("rd_ignored_in_dl", ioctl_wait, 0);

        for (int i = 0; i < 30; i++) begin
            gap();
            case ($urandom_range(0, 3))
                0:       ra = 25'($urandom_range(64, 200));
                1:       ra = 25'($urandom_range(1024, 4095));
                default: ra = 25'($urandom_range(16, 47));
            endcase
            rd_exp = 8'($urandom);
            do_write(ra, rd_exp, ra < HS_SIZE);
            model_write(ra, rd_exp);
        end
        check_chk("chk_dl_random");

        // Session drops the cycle after the strobe: the write still lands, then release.
        ioctl_addr = 25'd7; ioctl_dout = 8'h42; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        check("drop_wr_pulse", hs_write, 1);
        model_write(25'd7, 8'h42);
        step();
        check("drop_wr_done", hs_write, 0);
        step();
        check("drop_pause", pause_req, 0);
        check("drop_access", hs_access, 0);
        check_chk("chk_held");

        start_session(1'b0, 1'b1);
        check_chk("chk_cleared");
        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].is_wr) begin
                do_read(vecs[i].addr, vecs[i].exp_din);
                if (vecs[i].addr < HS_SIZE) exp_chk = exp_chk + vecs[i].exp_din;
            end
        end
        ioctl_wr = 1'b1; ioctl_addr = 25'd9; ioctl_dout = 8'hEE;
        step();
        ioctl_wr = 1'b0;
        check("wr_ignored_in_ul", {ioctl_wait, hs_write}, 0);
        for (int i = 0; i < 30; i++) begin
            gap();
            ra = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(64, 2000))
                                             : 25'($urandom_range(0, 63));
            rd_exp = model_read(ra);
            do_read(ra, rd_exp);
            if (ra < HS_SIZE) exp_chk = exp_chk + rd_exp;
        end
        check_chk("chk_ul_random");
        end_session();

        start_session(1'b1, 1'b0);
        do_write(25'd10, 8'h80, 1'b1);
        model_write(25'd10, 8'h80);
        do_write(25'd11, 8'h90, 1'b1);
        model_write(25'd11, 8'h90);
        end_session();
        check_chk("chk_80_90");
`ifdef HS_CHECKSUM_EN
        check("chk_literal_10", hs_chk, 8'h10);
`endif

        // Reset while a read is in flight.
        start_session(1'b0, 1'b1);
        ioctl_addr = 25'd3; ioctl_rd = 1'b1;
        step();
        ioctl_rd = 1'b0;
        reset = 1'b1;
        step();
        check("rrst_pause", pause_req, 0);
        check("rrst_wait", ioctl_wait, 0);
        check("rrst_access", hs_access, 0);
        check("rrst_addr", hs_address, 0);
        check("rrst_din", ioctl_din, 8'hFF);
        check("rrst_chk", hs_chk, 0);
        reset = 1'b0;
        ioctl_upload = 1'b0;
        step();

        diffs = 0;
        for (int i = 0; i < 1024; i++)
            if (core_ram[i] !== exp_img[i]) diffs++;
        check("ram_image_diffs", diffs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
